tt_mux_ctrl: RTL and testbench
==============================

# tt_mux_ctrl

Project-select controller and I/O mux that sits directly upstream and downstream of the per-project wrappers. It decodes the three chip-level control pins into a selected project index and an active flag. When active, it drives that project's `ena` and broadcasts the packed 18-bit `iw` bus; it returns the selected project's 24-bit `ow` bus to the pads. Every unselected project sees `ena=0`. When no project is active, every project sees an all-zero `iw`, which holds project reset low.

## Interface
- `N_PROJ`, default 4: number of attached project wrappers (2..32).
- `SEL_W`, default `$clog2(N_PROJ)`: width of the selection counter.
- `clk` in 1: controller clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ctrl_sel_rst_n` in 1: pad, asynchronous to `clk`; low clears the selection.
- `ctrl_sel_inc` in 1: pad, asynchronous; each rising edge advances the selection by one.
- `ctrl_ena` in 1: pad, asynchronous; high activates the selected project.
- `proj_clk`, `proj_rst_n` in 1 each: project clock and reset pads, forwarded.
- `pad_ui_in` in 8, `pad_uio_in` in 8: project input pads.
- `ow_all` in 24·N_PROJ: concatenated wrapper outputs; slice i = `{uio_oe, uio_out, uo_out}` of project i.
- `iw` out 18: broadcast `{uio_in, ui_in, rst_n, clk}`.
- `ena` out N_PROJ: one-hot project enable.
- `pad_uo_out`, `pad_uio_out`, `pad_uio_oe` out 8 each.
- `sel` out SEL_W: current selection, for status.
- `active` out 1: high in the ACTIVE state.

## Operation
- **Synchronizers.** `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena` each pass through a 2-flop synchronizer. The inc path adds a third flop for rising-edge detection, producing a one-cycle `inc_pulse`.
- **States.** IDLE and ACTIVE. Reset enters IDLE with `sel=0`.
- **IDLE → ACTIVE** when synchronized `ena_s=1` and `sel_rst_s=1`.
- **ACTIVE → IDLE** when `ena_s=0` or `sel_rst_s=0`.
- **Selection reset.** `sel_rst_s=0` forces `sel←0` and the IDLE state. It dominates every other event.
- **Increment in IDLE.** `inc_pulse` sets `sel←sel+1`. At `N_PROJ−1` it wraps to 0. `sel` never holds a value ≥ N_PROJ.
- **Increment in ACTIVE.** `inc_pulse` is dropped, not queued; `sel` stays frozen.
- **Same-edge events in IDLE.** If `inc_pulse` and `ena_s=1` occur on the same edge, the increment applies and ACTIVE starts on the new `sel`.
- **`ena` output.** Equals onehot(`sel`) when ACTIVE, otherwise all zero. It is decoded from registered state only, so it is glitch-free.
- **`iw` output.** When ACTIVE, `iw = {pad_uio_in, pad_ui_in, proj_rst_n, proj_clk}`, combinational passthrough. Otherwise `iw = 18'b0`.
- **Pad outputs.** When ACTIVE, `{pad_uio_oe, pad_uio_out, pad_uo_out} = ow_all[24·sel +: 24]`. Otherwise all zero, so `uio` pads act as inputs.

## Timing
- **Reset values.** `sel=0`, `active=0`, `ena=0`, `iw=0`, all pad outputs 0. Synchronizer flops reset to the following values:
  - `sel_rst` and `ena` paths: `sel_rst=1`, `ena=0`.
  - inc path: all flops to 0, so no spurious edge at reset release.
- **Control latency.** A pad level change first sampled at edge E0 takes effect at edge E0+2 (`sel`, `active`, `ena` change after E0+2). This holds for all three control pins.
- **Data path.** `iw` and the pad outputs follow their sources combinationally, with zero cycles of latency.
- **Increment spacing.** Increments need the `ctrl_sel_inc` pin high for ≥2 clk and low for ≥2 clk to be counted. Shorter pulses may be missed.
- **Reset mid-operation.** Asserting `rst_n` while ACTIVE clears every output immediately, asynchronously, without waiting for a clock edge.

## Structure
- Package `tt_mux_pkg`:
  - `IW_W=18`, `OW_W=24`
  - the state enum `{IDLE, ACTIVE}`
  - field offsets inside `iw` (clk 0, rst_n 1, ui_in 2..9, uio_in 10..17)
  - field offsets inside `ow` (uo_out 0..7, uio_out 8..15, uio_oe 16..23)
- Sub-module `tt_sync2`: 2-flop synchronizer with an async active-low reset and a reset-value parameter. Instantiated three times.
- Edge detection and the FSM live in the top module.

## Test plan
- **Reset.** Hold `rst_n=0` with all pads toggling → all outputs 0. Release with `ctrl_ena=0` → still all 0, `sel=0`.
- **Select and activate.** Three `ctrl_sel_inc` pulses (4 clk high / 4 clk low), then `ctrl_ena=1`. Required response:
  - `sel=3`, `ena=4'b1000`
  - `iw` equals the pads
  - pad outputs equal `ow_all[95:72]`
  - `active` rises exactly 2 edges after `ctrl_ena` is first sampled
- **Wrap.** `N_PROJ=4`, five increments from `sel=0` → `sel=1`.
- **Increments ignored while active.** Pulse `ctrl_sel_inc` while ACTIVE → `sel` unchanged. Drop `ctrl_ena` → `ena=0` and `iw=0` 2 edges later, `sel` still unchanged.
- **Selection reset dominates.** While ACTIVE with `sel=2`, pulse `ctrl_sel_rst_n` low while applying an inc edge → `sel=0` and IDLE after 2 edges. Then raise `ctrl_ena` → `ena=4'b0001`.
- **Async reset mid-operation.** ACTIVE with `sel=1`; assert `rst_n` between clock edges → `ena`, `iw` and pad outputs go to 0 before the next edge. After release, `sel=0`.

Source files
------------

// File: rtl/tt_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tt_mux_pkg
// Purpose : Shared widths, field offsets and FSM state type for the
//           project-select controller and I/O mux.
// Contents: IW_W / OW_W bus widths, field offsets inside the packed iw and
//           ow buses, state_t {IDLE, ACTIVE}.
// Revision: 1.0 - initial release
// ============================================================================
package tt_mux_pkg;

  localparam int IW_W  = 18;  // broadcast bus into each wrapper
  localparam int OW_W  = 24;  // return bus from each wrapper
  localparam int PAD_W = 8;   // width of every pad group

  // Field offsets inside iw = {uio_in, ui_in, rst_n, clk}
  localparam int IW_CLK   = 0;
  localparam int IW_RST_N = 1;
  localparam int IW_UI    = 2;
  localparam int IW_UIO   = 10;

  // Field offsets inside ow = {uio_oe, uio_out, uo_out}
  localparam int OW_UO      = 0;
  localparam int OW_UIO_OUT = 8;
  localparam int OW_UIO_OE  = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tt_sync2.sv
`default_nettype none
// ============================================================================
// Module  : tt_sync2
// Purpose : Two-flop synchronizer for a single asynchronous level.
// Ports   : clk   - destination clock
//           rst_n - asynchronous active-low reset (flops load RST_VAL)
//           d     - asynchronous input
//           q     - synchronized output, two clk edges behind d
// Revision: 1.0 - initial release
// ============================================================================
module tt_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tt_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tt_mux_ctrl
// Purpose : Project-select controller and I/O mux. Decodes the three control
//           pads into a selection index and an active flag, enables the
//           selected wrapper, broadcasts the input pads to it and returns its
//           outputs to the pads.
// Ports   : clk, rst_n              - controller clock, async active-low reset
//           ctrl_sel_rst_n          - pad, low clears the selection
//           ctrl_sel_inc            - pad, rising edge advances the selection
//           ctrl_ena                - pad, high activates the selected project
//           proj_clk, proj_rst_n    - project clock / reset pads, forwarded
//           pad_ui_in, pad_uio_in   - project input pads
//           ow_all                  - concatenated wrapper outputs
//           iw                      - broadcast {uio_in, ui_in, rst_n, clk}
//           ena                     - one-hot project enable
//           pad_uo_out, pad_uio_out, pad_uio_oe - project output pads
//           sel, active             - status
// Revision: 1.0 - initial release
// ============================================================================
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ = 4,
  parameter int SEL_W  = $clog2(N_PROJ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_sel_rst_n,
  input  logic                   ctrl_sel_inc,
  input  logic                   ctrl_ena,
  input  logic                   proj_clk,
  input  logic                   proj_rst_n,
  input  logic [PAD_W-1:0]       pad_ui_in,
  input  logic [PAD_W-1:0]       pad_uio_in,
  input  logic [OW_W*N_PROJ-1:0] ow_all,
  output logic [IW_W-1:0]        iw,
  output logic [N_PROJ-1:0]      ena,
  output logic [PAD_W-1:0]       pad_uo_out,
  output logic [PAD_W-1:0]       pad_uio_out,
  output logic [PAD_W-1:0]       pad_uio_oe,
  output logic [SEL_W-1:0]       sel,
  output logic                   active
);

  localparam logic [SEL_W-1:0] c_SEL_MAX = SEL_W'(N_PROJ - 1);

  // --------------------------------------------------------------------------
  // Control pad synchronizers
  // --------------------------------------------------------------------------
  logic w_sel_rst_s;
  logic w_inc_s;
  logic w_ena_s;
  logic r_inc_d;
  logic w_inc_pulse;

  // Resets to "not clearing" so the selection is usable right after rst_n.
  tt_sync2 #(.RST_VAL(1'b1)) u_sync_sel_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_sel_rst_n),
    .q     (w_sel_rst_s)
  );

  tt_sync2 #(.RST_VAL(1'b0)) u_sync_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_sel_inc),
    .q     (w_inc_s)
  );

  tt_sync2 #(.RST_VAL(1'b0)) u_sync_ena (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_ena),
    .q     (w_ena_s)
  );

  // Third flop on the inc path; resetting it to 0 alongside the synchronizer
  // guarantees no edge is seen at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_d <= 1'b0;
    end else begin
      r_inc_d <= w_inc_s;
    end
  end

  assign w_inc_pulse = w_inc_s & ~r_inc_d;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    if (!w_sel_rst_s) begin
      // Selection clear overrides increment and enable alike.
      w_state_nxt = IDLE;
      w_sel_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Increment and activation may coincide; the new index is the one
          // that goes active.
          if (w_inc_pulse) begin
            w_sel_nxt = (r_sel == c_SEL_MAX) ? '0 : r_sel + 1'b1;
          end
          if (w_ena_s) begin
            w_state_nxt = ACTIVE;
          end
        end
        ACTIVE: begin
          // Increments are discarded while a project is running.
          if (!w_ena_s) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and data mux
  // --------------------------------------------------------------------------
  logic [OW_W-1:0] w_ow_slice [N_PROJ];
  logic [OW_W-1:0] w_ow_sel;

  for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_ow_slice
    assign w_ow_slice[gi] = ow_all[gi*OW_W +: OW_W];
  end

  assign w_ow_sel = w_ow_slice[r_sel];
  assign sel      = r_sel;

  // Enables come only from registered state, so they never glitch.
  always_comb begin
    active      = (r_state == ACTIVE);
    ena         = '0;
    iw          = '0;
    pad_uo_out  = '0;
    pad_uio_out = '0;
    pad_uio_oe  = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      ena[i] = active && (r_sel == SEL_W'(i));
    end
    if (active) begin
      iw[IW_CLK]          = proj_clk;
      iw[IW_RST_N]        = proj_rst_n;
      iw[IW_UI +: PAD_W]  = pad_ui_in;
      iw[IW_UIO +: PAD_W] = pad_uio_in;
      pad_uo_out  = w_ow_sel[OW_UO +: PAD_W];
      pad_uio_out = w_ow_sel[OW_UIO_OUT +: PAD_W];
      pad_uio_oe  = w_ow_sel[OW_UIO_OE +: PAD_W];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tt_mux_ctrl
// Purpose : Self-checking bench for tt_mux_ctrl (N_PROJ = 4). Expected values
//           come from a cycle-level model: every control pad level becomes
//           visible to the controller two clk edges after it is sampled, an
//           increment is a 0->1 change of that delayed level, and the
//           selection/activation rules are applied with plain arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tt_mux_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_sel_rst_n;
  logic        ctrl_sel_inc;
  logic        ctrl_ena;
  logic        proj_clk;
  logic        proj_rst_n;
  logic [7:0]  pad_ui_in;
  logic [7:0]  pad_uio_in;
  logic [95:0] ow_all;
  logic [17:0] iw;
  logic [3:0]  ena;
  logic [7:0]  pad_uo_out;
  logic [7:0]  pad_uio_out;
  logic [7:0]  pad_uio_oe;
  logic [1:0]  sel;
  logic        active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_mux_ctrl #(.N_PROJ(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena),
    .proj_clk       (proj_clk),
    .proj_rst_n     (proj_rst_n),
    .pad_ui_in      (pad_ui_in),
    .pad_uio_in     (pad_uio_in),
    .ow_all         (ow_all),
    .iw             (iw),
    .ena            (ena),
    .pad_uo_out     (pad_uo_out),
    .pad_uio_out    (pad_uio_out),
    .pad_uio_oe     (pad_uio_oe),
    .sel            (sel),
    .active         (active)
  );

  // ---------------- reference model ----------------
  int m_sel;
  bit m_act;
  // Pad samples from earlier edges: [0] = one edge ago, [1] = two, [2] = three
  bit h_rst [3];
  bit h_ena [3];
  bit h_inc [3];

  task automatic model_reset();
    m_sel = 0;
    m_act = 1'b0;
    for (int k = 0; k < 3; k++) begin
      h_rst[k] = 1'b1;
      h_ena[k] = 1'b0;
      h_inc[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit rst_v, ena_v, inc_v;
    rst_v = h_rst[1];
    ena_v = h_ena[1];
    inc_v = h_inc[1] && !h_inc[2];
    if (!rst_v) begin
      m_sel = 0;
      m_act = 1'b0;
    end else if (!m_act) begin
      if (inc_v) m_sel = (m_sel + 1) % N;
      m_act = ena_v;
    end else if (!ena_v) begin
      m_act = 1'b0;
    end
    h_rst[2] = h_rst[1]; h_rst[1] = h_rst[0]; h_rst[0] = ctrl_sel_rst_n;
    h_ena[2] = h_ena[1]; h_ena[1] = h_ena[0]; h_ena[0] = ctrl_ena;
    h_inc[2] = h_inc[1]; h_inc[1] = h_inc[0]; h_inc[0] = ctrl_sel_inc;
  endtask

  function automatic logic [3:0] exp_ena();
    return m_act ? 4'(1 << m_sel) : 4'b0;
  endfunction

  function automatic logic [17:0] exp_iw();
    return m_act ? {pad_uio_in, pad_ui_in, proj_rst_n, proj_clk} : 18'b0;
  endfunction

  function automatic logic [23:0] exp_pads();
    return m_act ? ow_all[24*m_sel +: 24] : 24'b0;
  endfunction

  // Advance n clocks; returns at the falling edge with the model updated.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      @(negedge clk);
    end
  endtask

  task automatic pulse_inc(input int hi, input int lo);
    ctrl_sel_inc = 1'b1;
    step(hi);
    ctrl_sel_inc = 1'b0;
    step(lo);
  endtask

  task automatic clear_sel();
    ctrl_sel_rst_n = 1'b0;
    step(3);
    ctrl_sel_rst_n = 1'b1;
    step(3);
  endtask

  task automatic randomize_data();
    proj_clk   = 1'($urandom);
    proj_rst_n = 1'($urandom);
    pad_ui_in  = 8'($urandom);
    pad_uio_in = 8'($urandom);
    ow_all     = {32'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      ctrl_sel_rst_n = 1'($urandom);
      ctrl_sel_inc   = 1'($urandom);
      ctrl_ena       = 1'($urandom);
      randomize_data();
      step(1);
      checks++;
      if ({ena, iw, pad_uio_oe, pad_uio_out, pad_uo_out, sel, active} !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: ena=%h iw=%h pads=%h sel=%0d active=%b, required all 0",
                 i, ena, iw, {pad_uio_oe, pad_uio_out, pad_uo_out}, sel, active);
      end
    end
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(4);
    checks++;
    if (sel !== 2'd0 || active !== 1'b0 || ena !== 4'b0 || iw !== 18'b0) begin
      errors++;
      $display("FAIL reset_release: sel=%0d active=%b ena=%b iw=%h, required 0/0/0/0",
               sel, active, ena, iw);
    end
  endtask

  task automatic test_select_activate();
    repeat (3) pulse_inc(4, 4);
    checks++;
    if (sel !== 2'd3 || active !== 1'b0) begin
      errors++;
      $display("FAIL select_three: sel=%0d active=%b, required 3/0", sel, active);
    end
    ctrl_ena = 1'b1;
    step(1);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL activate_latency_e0: active=%b, required 0", active);
    end
    step(1);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL activate_latency_e1: active=%b, required 0", active);
    end
    step(1);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL activate_latency_e2: active=%b, required 1", active);
    end
    randomize_data();
    #1;
    checks++;
    if (ena !== 4'b1000 || iw !== {pad_uio_in, pad_ui_in, proj_rst_n, proj_clk}) begin
      errors++;
      $display("FAIL active_ena_iw: ena=%b iw=%h, required 1000 / %h",
               ena, iw, {pad_uio_in, pad_ui_in, proj_rst_n, proj_clk});
    end
    checks++;
    if ({pad_uio_oe, pad_uio_out, pad_uo_out} !== ow_all[95:72]) begin
      errors++;
      $display("FAIL active_pads: got %h, required %h",
               {pad_uio_oe, pad_uio_out, pad_uo_out}, ow_all[95:72]);
    end
  endtask

  task automatic test_inc_ignored();
    pulse_inc(4, 4);
    checks++;
    if (sel !== 2'd3 || ena !== 4'b1000) begin
      errors++;
      $display("FAIL inc_while_active: sel=%0d ena=%b, required 3 / 1000", sel, ena);
    end
    ctrl_ena = 1'b0;
    step(2);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL deactivate_early: active=%b, required 1", active);
    end
    step(1);
    checks++;
    if (ena !== 4'b0 || iw !== 18'b0 || sel !== 2'd3) begin
      errors++;
      $display("FAIL deactivate: ena=%b iw=%h sel=%0d, required 0 / 0 / 3", ena, iw, sel);
    end
  endtask

  task automatic test_wrap();
    clear_sel();
    repeat (5) pulse_inc(4, 4);
    checks++;
    if (sel !== 2'd1 || int'(sel) != m_sel) begin
      errors++;
      $display("FAIL wrap: sel=%0d, required 1 (model %0d)", sel, m_sel);
    end
  endtask

  task automatic test_sel_rst_dominates();
    clear_sel();
    repeat (2) pulse_inc(4, 4);
    ctrl_ena = 1'b1;
    step(3);
    checks++;
    if (sel !== 2'd2 || active !== 1'b1) begin
      errors++;
      $display("FAIL setup_sel2: sel=%0d active=%b, required 2/1", sel, active);
    end
    ctrl_sel_rst_n = 1'b0;
    ctrl_sel_inc   = 1'b1;
    step(3);
    checks++;
    if (sel !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL sel_rst_dominates: sel=%0d active=%b, required 0/0", sel, active);
    end
    ctrl_sel_rst_n = 1'b1;
    step(3);
    checks++;
    if (ena !== 4'b0001) begin
      errors++;
      $display("FAIL reactivate_sel0: ena=%b, required 0001", ena);
    end
    ctrl_sel_inc = 1'b0;
    step(3);
  endtask

  task automatic test_async_reset();
    ctrl_ena = 1'b0;
    step(3);
    clear_sel();
    pulse_inc(4, 4);
    ctrl_ena = 1'b1;
    step(3);
    checks++;
    if (sel !== 2'd1 || ena !== 4'b0010) begin
      errors++;
      $display("FAIL setup_sel1: sel=%0d ena=%b, required 1 / 0010", sel, ena);
    end
    randomize_data();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ena !== 4'b0 || iw !== 18'b0 || {pad_uio_oe, pad_uio_out, pad_uo_out} !== 24'b0
        || active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ena=%b iw=%h pads=%h active=%b, required all 0",
               ena, iw, {pad_uio_oe, pad_uio_out, pad_uo_out}, active);
    end
    model_reset();
    step(2);
    rst_n    = 1'b1;
    ctrl_ena = 1'b0;
    step(4);
    checks++;
    if (sel !== 2'd0 || active !== 1'b0) begin
      errors++;
      $display("FAIL after_async_reset: sel=%0d active=%b, required 0/0", sel, active);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ctrl_ena = ~ctrl_ena;
      ctrl_sel_rst_n = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 2) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
      proj_clk   = 1'($urandom);
      proj_rst_n = 1'($urandom);
      pad_ui_in  = 8'($urandom);
      pad_uio_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ow_all = {32'($urandom), 32'($urandom), 32'($urandom)};
      step(1);
      checks++;
      if (int'(sel) != m_sel || active !== m_act || ena !== exp_ena() || iw !== exp_iw()
          || {pad_uio_oe, pad_uio_out, pad_uo_out} !== exp_pads()) begin
        errors++;
        $display("FAIL random[%0d]: sel=%0d active=%b ena=%b iw=%h pads=%h, required sel=%0d active=%b ena=%b iw=%h pads=%h",
                 i, sel, active, ena, iw, {pad_uio_oe, pad_uio_out, pad_uo_out},
                 m_sel, m_act, exp_ena(), exp_iw(), exp_pads());
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b0;
    proj_clk       = 1'b0;
    proj_rst_n     = 1'b0;
    pad_ui_in      = '0;
    pad_uio_in     = '0;
    ow_all         = '0;
    model_reset();

    test_reset();
    test_select_activate();
    test_inc_ignored();
    test_wrap();
    test_sel_rst_dominates();
    test_async_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
